// File: rtl/rvfi_trace_buffer_if.sv
// RVFI retirement packet in, trace beat out (valid/ready), as one bundle.
interface rvfi_trace_buffer_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            rvfi_valid;
    logic [63:0]     rvfi_order;
    logic [ILEN-1:0] rvfi_insn;
    logic            rvfi_trap;
    logic [XLEN-1:0] rvfi_pc_rdata;
    logic [XLEN-1:0] rvfi_pc_wdata;
    logic [4:0]      rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rd_wdata;

    logic            trace_valid;
    logic            trace_ready;
    logic [63:0]     trace_order;
    logic [ILEN-1:0] trace_insn;
    logic            trace_trap;
    logic [XLEN-1:0] trace_pc;
    logic [XLEN-1:0] trace_next_pc;
    logic [4:0]      trace_rd_addr;
    logic [XLEN-1:0] trace_rd_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trace_ready,
        input  trace_valid, trace_order, trace_insn, trace_trap, trace_pc,
               trace_next_pc, trace_rd_addr, trace_rd_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trace_ready,
        output trace_valid, trace_order, trace_insn, trace_trap, trace_pc,
               trace_next_pc, trace_rd_addr, trace_rd_wdata
    );
endinterface

// File: rtl/rvfi_trace_buffer.sv
// Show-ahead retirement-trace FIFO with order-continuity check and
// saturating overflow drop counter.
module rvfi_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    rvfi_trace_buffer_if.slave       bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic                     order_error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [63:0]   expected;
    logic          resync;
    logic          pop;
    logic          push;
    logic          drop;

    assign pop  = bus.trace_valid && bus.trace_ready;
    assign push = bus.rvfi_valid && ((level != FULL_LEVEL) || pop);
    assign drop = bus.rvfi_valid && (level == FULL_LEVEL) && !pop;

    // Storage carries no reset; outputs are masked by level instead.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wptr] <= '{
                order:    bus.rvfi_order,
                insn:     bus.rvfi_insn,
                trap:     bus.rvfi_trap,
                pc:       bus.rvfi_pc_rdata,
                next_pc:  bus.rvfi_pc_wdata,
                rd_addr:  bus.rvfi_rd_addr,
                rd_wdata: bus.rvfi_rd_wdata
            };
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            order_error <= 1'b0;
            expected    <= '0;
            resync      <= 1'b0;
        end else if (clear) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            order_error <= 1'b0;
            resync      <= 1'b1;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 16'd1;
            end
            // Dropped packets still advance the expected order.
            if (bus.rvfi_valid) begin
                if (!resync && (bus.rvfi_order != expected)) order_error <= 1'b1;
                expected <= bus.rvfi_order + 64'd1;
                resync   <= 1'b0;
            end
        end
    end

    assign head            = mem[rptr];
    assign bus.trace_valid = (level != '0);

    always_comb begin
        bus.trace_order    = '0;
        bus.trace_insn     = '0;
        bus.trace_trap     = 1'b0;
        bus.trace_pc       = '0;
        bus.trace_next_pc  = '0;
        bus.trace_rd_addr  = '0;
        bus.trace_rd_wdata = '0;
        if (bus.trace_valid) begin
            bus.trace_order    = head.order;
            bus.trace_insn     = head.insn;
            bus.trace_trap     = head.trap;
            bus.trace_pc       = head.pc;
            bus.trace_next_pc  = head.next_pc;
            bus.trace_rd_addr  = head.rd_addr;
            bus.trace_rd_wdata = head.rd_wdata;
        end
    end
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed vector bench for rvfi_trace_buffer: FIFO order, overflow,
// order check, clear priority, counter saturation and async reset.
module tb_rvfi_trace_buffer;
    logic        clock;
    logic        reset;
    logic        clear;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic        order_error;

    int n_pass;
    int n_total;

    rvfi_trace_buffer_if #(.XLEN(64), .ILEN(32)) bus ();

    rvfi_trace_buffer #(.DEPTH(8), .XLEN(64), .ILEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .clear       (clear),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .order_error (order_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [63:0] o;
        logic        r;
        logic        c;
        logic        ev;
        logic [63:0] eo;
        int          el;
        logic        eovf;
        int          ed;
        logic        eoe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [63:0] o, logic r, logic c, logic ev,
                                logic [63:0] eo, int el, logic eovf, int ed, logic eoe);
        vec_t t;
        t.v = v; t.o = o; t.r = r; t.c = c; t.ev = ev; t.eo = eo;
        t.el = el; t.eovf = eovf; t.ed = ed; t.eoe = eoe;
        return t;
    endfunction

    // Payload fields are derived from the order so the head can be checked.
    function automatic logic [63:0] pc_of(logic [63:0] o);
        return 64'h0000_0000_8000_0000 + (o << 2);
    endfunction
    function automatic logic [31:0] insn_of(logic [63:0] o);
        logic [31:0] lo;
        lo = o[31:0];
        return 32'h0000_0013 ^ (lo << 7);
    endfunction
    function automatic logic [63:0] wd_of(logic [63:0] o);
        return {o[31:0], ~o[31:0]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(logic v, logic [63:0] o, logic r, logic c);
        bus.rvfi_valid    = v;
        bus.rvfi_order    = o;
        bus.rvfi_insn     = insn_of(o);
        bus.rvfi_trap     = o[1];
        bus.rvfi_pc_rdata = pc_of(o);
        bus.rvfi_pc_wdata = pc_of(o) + 64'd4;
        bus.rvfi_rd_addr  = o[4:0];
        bus.rvfi_rd_wdata = wd_of(o);
        bus.trace_ready   = r;
        clear             = c;
    endtask

    task automatic check_state(string tag, logic ev, logic [63:0] eo, int el,
                               logic eovf, int ed, logic eoe);
        logic [4:0] erd;
        erd = eo[4:0];
        check({tag, " trace_valid"}, 64'(bus.trace_valid), 64'(ev));
        check({tag, " trace_order"}, bus.trace_order, ev ? eo : 64'd0);
        check({tag, " trace_insn"}, 64'(bus.trace_insn), ev ? 64'(insn_of(eo)) : 64'd0);
        check({tag, " trace_trap"}, 64'(bus.trace_trap), ev ? 64'(eo[1]) : 64'd0);
        check({tag, " trace_pc"}, bus.trace_pc, ev ? pc_of(eo) : 64'd0);
        check({tag, " trace_next_pc"}, bus.trace_next_pc, ev ? pc_of(eo) + 64'd4 : 64'd0);
        check({tag, " trace_rd_addr"}, 64'(bus.trace_rd_addr), ev ? 64'(erd) : 64'd0);
        check({tag, " trace_rd_wdata"}, bus.trace_rd_wdata, ev ? wd_of(eo) : 64'd0);
        check({tag, " level"}, 64'(level), 64'(el));
        check({tag, " overflow"}, 64'(overflow), 64'(eovf));
        check({tag, " drop_count"}, 64'(drop_count), 64'(ed));
        check({tag, " order_error"}, 64'(order_error), 64'(eoe));
    endtask

    task automatic step(logic v, logic [63:0] o, logic r, logic c);
        drive(v, o, r, c);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] heads [7];
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);

        // Stream of four with ready high.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 64'(k), 1, 0, 1, 64'(k), 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Fill to full with ready low, then two drops.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 64'(k), 0, 0, 1, 0, k + 1, 0, 0, 0));
        vecs.push_back(mk(1, 8, 0, 0, 1, 0, 8, 1, 1, 0));
        vecs.push_back(mk(1, 9, 0, 0, 1, 0, 8, 1, 2, 0));
        // Full with simultaneous push and pop: no drop.
        vecs.push_back(mk(1, 10, 1, 0, 1, 1, 8, 1, 2, 0));
        heads = '{64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd10};
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 0, 1, 0, 1, heads[k], 7 - k, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 2, 0));
        // Order gap 1 -> 3.
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 1, 3, 1, 0, 0, 1));
        vecs.push_back(mk(1, 4, 1, 0, 1, 4, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        // Three queued, then clear with a same-cycle packet and pop.
        vecs.push_back(mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 1));
        vecs.push_back(mk(1, 6, 0, 0, 1, 5, 2, 0, 0, 1));
        vecs.push_back(mk(1, 7, 0, 0, 1, 5, 3, 0, 0, 1));
        vecs.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 20, 0, 0, 1, 20, 1, 0, 0, 0));
        vecs.push_back(mk(1, 21, 1, 0, 1, 21, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].o, vecs[i].r, vecs[i].c);
            check_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].el,
                        vecs[i].eovf, vecs[i].ed, vecs[i].eoe);
        end

        // Saturating drop counter.
        step(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(1, 64'(k), 0, 0);
        for (int k = 1; k <= 65540; k++) begin
            step(1, 64'(7 + k), 0, 0);
            if (k == 65534) check("sat drop_count 65534", 64'(drop_count), 64'hFFFE);
            if (k == 65535) check("sat drop_count 65535", 64'(drop_count), 64'hFFFF);
        end
        check_state("sat end", 1, 0, 8, 1, 16'hFFFF, 0);

        // Async reset mid-burst, between clock edges.
        drive(1, 64'd70000, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_state("async reset", 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0);
        reset = 1'b0;

        // First retirement after reset must be order 0.
        step(1, 1, 0, 0);
        check_state("post-reset order1", 1, 1, 1, 0, 0, 1);
        step(1, 2, 0, 0);
        check_state("post-reset order2", 1, 1, 2, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
